// File: rtl/oport_channel_fifo.sv
`default_nettype none
// ============================================================================
// Module  : oport_channel_fifo
// Brief   : Multi-channel output port; latched register or FWFT FIFO per channel.
// Revision: 1.0
// ============================================================================
module oport_channel_fifo #(
   parameter int WIDTH    = 32,
   parameter int CHANNELS = 4,
   parameter int DEPTH    = 8,
   parameter int MODE     = 1,
   localparam int SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
   localparam int LVL_W   = $clog2(DEPTH) + 1
) (
   input  logic                      clock,
   input  logic                      clear,
   input  logic [WIDTH-1:0]          BusMuxOut,
   input  logic                      OPortIn,
   input  logic [SEL_W-1:0]          ch_sel,
   input  logic [CHANNELS-1:0]       ovf_clr,
   input  logic [CHANNELS-1:0]       out_ready,
   output logic [CHANNELS*WIDTH-1:0] out_data,
   output logic [CHANNELS-1:0]       out_valid,
   output logic [CHANNELS-1:0]       full,
   output logic                      sel_full,
   output logic [CHANNELS-1:0]       ovf,
   output logic [CHANNELS*LVL_W-1:0] level
);

   localparam int NSEL = 1 << SEL_W;

   logic            sel_valid;
   logic [NSEL-1:0] full_ext;

   assign sel_valid = (32'(ch_sel) < CHANNELS);

   // Zero-padded so that out-of-range selects read as not full.
   assign full_ext  = NSEL'(full);
   assign sel_full  = full_ext[ch_sel];

   for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
      localparam logic [SEL_W-1:0] CH_ID = SEL_W'(k);

      logic hit;
      assign hit = OPortIn && sel_valid && (ch_sel == CH_ID);

      if (MODE == 0) begin : g_reg
         logic [WIDTH-1:0] data_q;
         logic             written;
         logic             unused_sink;

         always_ff @(posedge clock or negedge clear) begin
            if (!clear) begin
               data_q  <= '0;
               written <= 1'b0;
            end else if (hit) begin
               data_q  <= BusMuxOut;
               written <= 1'b1;
            end
         end

         assign out_data[k*WIDTH +: WIDTH] = data_q;
         assign out_valid[k]               = written;
         assign full[k]                    = 1'b0;
         assign ovf[k]                     = 1'b0;
         assign level[k*LVL_W +: LVL_W]    = LVL_W'(written);
         assign unused_sink                = out_ready[k] ^ ovf_clr[k];
      end else begin : g_fifo
         localparam int               PTR_W    = $clog2(DEPTH);
         localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

         logic [WIDTH-1:0] mem [DEPTH];
         logic [PTR_W-1:0] rd_ptr;
         logic [PTR_W-1:0] wr_ptr;
         logic [LVL_W-1:0] cnt;
         logic             ovf_q;
         logic             not_empty;
         logic             is_full;
         logic             pop;
         logic             push_ok;
         logic             drop;

         assign not_empty = (cnt != '0);
         assign is_full   = (cnt == FULL_LVL);
         assign pop       = not_empty && out_ready[k];
         // A pop in the same cycle frees the slot, so a push at full still lands.
         assign push_ok   = hit && (!is_full || pop);
         assign drop      = hit && is_full && !pop;

         always_ff @(posedge clock) begin
            if (push_ok) begin
               mem[wr_ptr] <= BusMuxOut;
            end
         end

         always_ff @(posedge clock or negedge clear) begin
            if (!clear) begin
               rd_ptr <= '0;
               wr_ptr <= '0;
               cnt    <= '0;
               ovf_q  <= 1'b0;
            end else begin
               if (push_ok) begin
                  wr_ptr <= wr_ptr + 1'b1;
               end
               if (pop) begin
                  rd_ptr <= rd_ptr + 1'b1;
               end
               case ({push_ok, pop})
                  2'b10:   cnt <= cnt + 1'b1;
                  2'b01:   cnt <= cnt - 1'b1;
                  default: cnt <= cnt;
               endcase
               if (drop) begin
                  ovf_q <= 1'b1;
               end else if (ovf_clr[k]) begin
                  ovf_q <= 1'b0;
               end
            end
         end

         // Memory is not reset; gating keeps the head word at zero while empty.
         assign out_data[k*WIDTH +: WIDTH] = not_empty ? mem[rd_ptr] : '0;
         assign out_valid[k]               = not_empty;
         assign full[k]                    = is_full;
         assign ovf[k]                     = ovf_q;
         assign level[k*LVL_W +: LVL_W]    = cnt;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_oport_channel_fifo.sv
`default_nettype none
// Bench for oport_channel_fifo: FIFO-mode instance with per-channel scoreboard,
// plus a latched-register instance.
module tb_oport_channel_fifo;

   localparam int W  = 32;
   localparam int NC = 5;
   localparam int D  = 8;
   localparam int LW = 4;

   logic          clock = 1'b0;
   logic          clear = 1'b0;
   logic [W-1:0]  bus = '0;
   logic          oport_in = 1'b0;
   logic [2:0]    ch_sel = '0;
   logic [NC-1:0] ovf_clr = '0;
   logic [NC-1:0] out_ready = '0;
   logic [NC*W-1:0]  out_data;
   logic [NC-1:0]    out_valid;
   logic [NC-1:0]    full;
   logic             sel_full;
   logic [NC-1:0]    ovf;
   logic [NC*LW-1:0] level;

   logic          oport_in0 = 1'b0;
   logic [1:0]    ch_sel0 = '0;
   logic [3:0]    ovf_clr0 = '0;
   logic [3:0]    out_ready0 = '0;
   logic [4*W-1:0]  out_data0;
   logic [3:0]      out_valid0;
   logic [3:0]      full0;
   logic            sel_full0;
   logic [3:0]      ovf0;
   logic [4*LW-1:0] level0;

   int         checks = 0;
   int         failures = 0;
   logic [W-1:0] mq [NC][$];
   logic [NC-1:0] movf = '0;

   always #5 clock = ~clock;

   oport_channel_fifo #(.WIDTH(W), .CHANNELS(NC), .DEPTH(D), .MODE(1)) dut (
      .clock(clock), .clear(clear), .BusMuxOut(bus), .OPortIn(oport_in), .ch_sel(ch_sel),
      .ovf_clr(ovf_clr), .out_ready(out_ready), .out_data(out_data), .out_valid(out_valid),
      .full(full), .sel_full(sel_full), .ovf(ovf), .level(level)
   );

   oport_channel_fifo #(.WIDTH(W), .CHANNELS(4), .DEPTH(D), .MODE(0)) dut_reg (
      .clock(clock), .clear(clear), .BusMuxOut(bus), .OPortIn(oport_in0), .ch_sel(ch_sel0),
      .ovf_clr(ovf_clr0), .out_ready(out_ready0), .out_data(out_data0), .out_valid(out_valid0),
      .full(full0), .sel_full(sel_full0), .ovf(ovf0), .level(level0)
   );

   task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_state(input string tag);
      for (int k = 0; k < NC; k++) begin
         chk($sformatf("%s_level%0d", tag, k), 160'(level[k*LW +: LW]), 160'(mq[k].size()));
         chk($sformatf("%s_valid%0d", tag, k), 160'(out_valid[k]), 160'(mq[k].size() != 0));
         chk($sformatf("%s_full%0d", tag, k), 160'(full[k]), 160'(mq[k].size() == D));
         chk($sformatf("%s_ovf%0d", tag, k), 160'(ovf[k]), 160'(movf[k]));
         if (mq[k].size() != 0)
            chk($sformatf("%s_head%0d", tag, k), 160'(out_data[k*W +: W]), 160'(mq[k][0]));
      end
   endtask

   // Pops are compared against the scoreboard before the edge that consumes them.
   task automatic cycle();
      logic drop;
      for (int k = 0; k < NC; k++) begin
         if (out_ready[k] && mq[k].size() != 0) begin
            chk($sformatf("pop_valid%0d", k), 160'(out_valid[k]), 160'(1));
            chk($sformatf("pop_data%0d", k), 160'(out_data[k*W +: W]), 160'(mq[k].pop_front()));
         end
      end
      for (int k = 0; k < NC; k++) begin
         drop = 1'b0;
         if (oport_in && (32'(ch_sel) == k)) begin
            if (mq[k].size() < D) mq[k].push_back(bus);
            else drop = 1'b1;
         end
         if (drop) movf[k] = 1'b1;
         else if (ovf_clr[k]) movf[k] = 1'b0;
      end
      @(negedge clock);
   endtask

   task automatic push(input int ch, input logic [W-1:0] d);
      ch_sel = 3'(ch);
      bus = d;
      oport_in = 1'b1;
      cycle();
      oport_in = 1'b0;
   endtask

   initial begin
      repeat (2) @(negedge clock);
      check_state("rst");
      chk("rst_data", 160'(out_data), 160'(0));
      chk("rst_reg_valid", 160'(out_valid0), 160'(0));
      chk("rst_reg_level", 160'(level0), 160'(0));
      clear = 1'b1;
      cycle();

      // Asynchronous reset mid-cycle with data in flight
      push(0, 32'h1); push(0, 32'h2); push(0, 32'h3);
      check_state("t1_pre");
      @(posedge clock);
      #2 clear = 1'b0;
      #1;
      chk("t1_async_valid", 160'(out_valid), 160'(0));
      chk("t1_async_level", 160'(level), 160'(0));
      chk("t1_async_data", 160'(out_data), 160'(0));
      chk("t1_async_ovf", 160'(ovf), 160'(0));
      for (int k = 0; k < NC; k++) mq[k].delete();
      movf = '0;
      @(negedge clock);
      clear = 1'b1;
      cycle();
      check_state("t1_post");

      // Ordering through first-word fall-through
      push(2, 32'h4); push(2, 32'h5); push(2, 32'h6);
      check_state("t2_pre");
      out_ready[2] = 1'b1;
      repeat (3) cycle();
      out_ready = '0;
      check_state("t2_post");

      // Overflow, sticky flag and clear
      for (int i = 0; i < 9; i++) begin
         push(0, 32'h100 + i);
         if (i == 7) check_state("t3_full");
      end
      check_state("t3_ovf");
      ch_sel = 3'd0; #1;
      chk("t3_sel_full_ch0", 160'(sel_full), 160'(1));
      ch_sel = 3'd5; #1;
      chk("t3_sel_full_ch5", 160'(sel_full), 160'(0));
      out_ready[0] = 1'b1;
      repeat (9) cycle();
      out_ready = '0;
      check_state("t3_drained");
      ovf_clr[0] = 1'b1;
      cycle();
      ovf_clr = '0;
      check_state("t3_cleared");

      // Push at full with simultaneous pop is accepted
      for (int i = 0; i < 8; i++) push(1, 32'h200 + i);
      check_state("t4_full");
      ch_sel = 3'd1; bus = 32'hAA; oport_in = 1'b1; out_ready[1] = 1'b1;
      cycle();
      oport_in = 1'b0;
      check_state("t4_pushpop");
      repeat (8) cycle();
      out_ready = '0;
      check_state("t4_drained");

      // Overflow set wins over a same-cycle clear
      for (int i = 0; i < 8; i++) push(1, 32'h280 + i);
      ch_sel = 3'd1; bus = 32'hBB; oport_in = 1'b1; ovf_clr[1] = 1'b1;
      cycle();
      oport_in = 1'b0;
      check_state("t4_set_prio");
      cycle();
      ovf_clr = '0;
      check_state("t4_clr");
      out_ready[1] = 1'b1;
      repeat (8) cycle();
      out_ready = '0;

      // Out-of-range select and channel isolation
      push(5, 32'hDEAD);
      push(7, 32'hBEEF);
      check_state("t5_badsel");
      for (int i = 0; i < 4; i++) push(1, 32'h300 + i);
      check_state("t5_iso");
      push(0, 32'h10); push(2, 32'h20); push(4, 32'h40);
      out_ready = '1;
      cycle();
      out_ready = '0;
      check_state("t5_multipop");

      // Latched-register mode
      ch_sel0 = 2'd0; bus = 32'h173; oport_in0 = 1'b1;
      @(negedge clock);
      oport_in0 = 1'b0;
      chk("t6_data0", 160'(out_data0[31:0]), 160'(32'h173));
      chk("t6_valid0", 160'(out_valid0), 160'(4'b0001));
      chk("t6_level0", 160'(level0), 160'(16'h0001));
      for (int i = 0; i < 3; i++) begin
         out_ready0 = ~out_ready0;
         @(negedge clock);
         chk("t6_hold", 160'(out_data0[31:0]), 160'(32'h173));
      end
      ch_sel0 = 2'd3; bus = 32'h5A5; oport_in0 = 1'b1;
      @(negedge clock);
      oport_in0 = 1'b0;
      chk("t6_data3", 160'(out_data0[127:96]), 160'(32'h5A5));
      chk("t6_data0_kept", 160'(out_data0[31:0]), 160'(32'h173));
      chk("t6_valid_mix", 160'(out_valid0), 160'(4'b1001));
      ch_sel0 = 2'd0; oport_in0 = 1'b1;
      for (int i = 0; i < 10; i++) begin
         bus = 32'h600 + i;
         @(negedge clock);
      end
      oport_in0 = 1'b0;
      chk("t6_last_write", 160'(out_data0[31:0]), 160'(32'h609));
      chk("t6_never_full", 160'(full0), 160'(0));
      chk("t6_never_ovf", 160'(ovf0), 160'(0));
      chk("t6_sel_full", 160'(sel_full0), 160'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
